// File: rtl/mux21_rr_arbiter_if.sv
// Bundle of request, data, grant and output signals for the two-requester arbiter.
//
//   req_a, req_b : requests from A and B (held high for a whole transaction)
//   a, b         : WIDTH-bit request data from A and B
//   gnt_a, gnt_b : registered grants; at most one is high
//   s            : registered mux select, 1 only while B owns the path
//   y, yv        : registered selected word and its valid flag
//
// master : requester/consumer side (drives requests and data)
// slave  : arbiter side (drives grants, select and output word)
interface mux21_rr_arbiter_if #(
    parameter int unsigned WIDTH = 1
) ();
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gnt_a;
    logic             gnt_b;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             yv;

    modport master (
        output req_a, req_b, a, b,
        input  gnt_a, gnt_b, s, y, yv
    );

    modport slave (
        input  req_a, req_b, a, b,
        output gnt_a, gnt_b, s, y, yv
    );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared, registered 2:1 data multiplexer.
// One requester owns the path at a time; the owner's word is registered onto y with yv
// marking a cycle in which y carries owner data. On a tie from idle the requester that
// was not granted last wins (A wins the first tie after reset).
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state immediately
//   bus   : mux21_rr_arbiter_if.slave (req_a, req_b, a, b in; gnt_a, gnt_b, s, y, yv out)
//
// Parameters:
//   WIDTH    : data word width (>= 1); must match the interface WIDTH
//   MAX_HOLD : max consecutive grant cycles under contention (>= 2), timeout build only
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to bound how long an owner may keep the path
// while the other requester is waiting. Without it an owner holds the path as long as its
// request stays high.
module mux21_rr_arbiter #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux21_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntA = 2'd1,
        StGntB = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_b_q, last_b_d;  // 1: B was the most recent grantee
    logic             gnt_a_q, gnt_b_q, s_q, yv_q;
    logic [WIDTH-1:0] y_q;
    logic             force_switch;

    // Out-of-range MAX_HOLD leaves this marker block in the hierarchy; it also keeps the
    // parameter referenced in the default build where nothing else consumes it.
    if (MAX_HOLD < 2) begin : g_max_hold_out_of_range
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned     HoldW    = $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

    // Owner has used its last allowed cycle and the other side is waiting.
    always_comb begin
        force_switch = 1'b0;
        if (hold_cnt_q == HoldLast) begin
            force_switch = ((state_q == StGntA) && bus.req_b) ||
                           ((state_q == StGntB) && bus.req_a);
        end
    end

    // Cleared on any state change (grant entry or return to idle); saturates at HoldLast so
    // contention arriving late in a long grant still forces a switch.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end else if ((state_q != StIdle) && (hold_cnt_q != HoldLast)) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
    end
`else
    assign force_switch = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        case (state_q)
            StIdle: begin
                if (bus.req_a && bus.req_b) begin
                    state_d = last_b_q ? StGntA : StGntB;
                end else if (bus.req_a) begin
                    state_d = StGntA;
                end else if (bus.req_b) begin
                    state_d = StGntB;
                end
            end
            StGntA: begin
                // Hand over directly when A leaves or times out; no idle bubble.
                if (!bus.req_a || force_switch) begin
                    state_d = bus.req_b ? StGntB : StIdle;
                end
            end
            StGntB: begin
                if (!bus.req_b || force_switch) begin
                    state_d = bus.req_a ? StGntA : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_d == StGntA) && (state_q != StGntA)) begin
            last_b_d = 1'b0;
        end else if ((state_d == StGntB) && (state_q != StGntB)) begin
            last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_b_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            s_q        <= 1'b0;
            y_q        <= '0;
            yv_q       <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            gnt_a_q    <= (state_d == StGntA);
            gnt_b_q    <= (state_d == StGntB);
            s_q        <= (state_d == StGntB);
            // Data path follows the grant already in place, one cycle behind the FSM.
            yv_q       <= gnt_a_q | gnt_b_q;
            if (gnt_a_q || gnt_b_q) begin
                y_q <= gnt_b_q ? bus.b : bus.a;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.s     = s_q;
    assign bus.y     = y_q;
    assign bus.yv    = yv_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Self-checking bench for mux21_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level ownership model kept in the bench.
module tb_mux21_rr_arbiter;

    localparam int unsigned W  = 4;
    localparam int unsigned MH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mux21_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux21_rr_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: who owns the path (0 none, 1 A, 2 B), who was granted last,
    // how many cycles the current owner has held it, and the expected output word.
    int         own;
    int         last;
    int         held;
    logic [W-1:0] m_y;
    logic       m_yv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gnt_a"}, 32'(bus.gnt_a), 32'(own == 1));
        check({tag, ".gnt_b"}, 32'(bus.gnt_b), 32'(own == 2));
        check({tag, ".s"},     32'(bus.s),     32'(own == 2));
        check({tag, ".y"},     32'(bus.y),     32'(m_y));
        check({tag, ".yv"},    32'(bus.yv),    32'(m_yv));
    endtask

    task automatic model_reset();
        own  = 0;
        last = 2;
        held = 0;
        m_y  = '0;
        m_yv = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  nxt;
        bit  mine, oth, forced;
        if (own != 0) begin
            m_y  = (own == 2) ? bus.b : bus.a;
            m_yv = 1'b1;
        end else begin
            m_yv = 1'b0;
        end

        if (own == 0) begin
            if (bus.req_a && bus.req_b) nxt = (last == 1) ? 2 : 1;
            else if (bus.req_a)         nxt = 1;
            else if (bus.req_b)         nxt = 2;
            else                        nxt = 0;
        end else begin
            mine   = (own == 1) ? bus.req_a : bus.req_b;
            oth    = (own == 1) ? bus.req_b : bus.req_a;
            forced = TimeoutEn && (held >= int'(MH)) && oth;
            if (mine && !forced) nxt = own;
            else if (oth)        nxt = 3 - own;
            else                 nxt = 0;
        end

        if (nxt == 0) begin
            held = 0;
        end else if (nxt != own) begin
            held = 1;
            last = nxt;
        end else begin
            held++;
        end
        own = nxt;
    endtask

    task automatic drive(input bit ra, input bit rb, input logic [W-1:0] da,
                         input logic [W-1:0] db);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.a     = da;
        bus.b     = db;
    endtask

    // One clock: update the model at the edge, compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check the immediate clear, release before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bit ra, rb;

        drive(1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Async reset in the middle of a B grant, then restart with A.
        drive(1'b0, 1'b1, 4'h0, 4'h1);
        tick("rst_setup0");
        tick("rst_setup1");
        check("rst_setup_yv", 32'(bus.yv), 32'd1);
        async_reset("rst_mid_gnt_b");
        drive(1'b1, 1'b0, 4'h0, 4'h1);
        tick("rst_release");
        check("rst_release_gnt_a", 32'(bus.gnt_a), 32'd1);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        tick("rst_drain0");
        tick("rst_drain1");

        // First tie after reset goes to A; dropping A hands over straight to B.
        async_reset("tie_pre_reset");
        drive(1'b1, 1'b1, 4'h3, 4'hc);
        tick("tie_first");
        check("tie_first_gnt_a", 32'(bus.gnt_a), 32'd1);
        tick("tie_hold");
        drive(1'b0, 1'b1, 4'h3, 4'hc);
        tick("tie_handover");
        check("tie_handover_gnt_b", 32'(bus.gnt_b), 32'd1);
        drive(1'b0, 1'b0, 4'h3, 4'hc);
        tick("tie_idle");
        drive(1'b1, 1'b1, 4'h3, 4'hc);
        tick("tie_rewin");
        check("tie_rewin_gnt_a", 32'(bus.gnt_a), 32'd1);

        // Data path through B, then idle with y held.
        drive(1'b0, 1'b0, 4'h0, 4'h1);
        tick("dp_idle");
        drive(1'b0, 1'b1, 4'h0, 4'h1);
        tick("dp_grant");
        tick("dp_data");
        check("dp_y", 32'(bus.y), 32'd1);
        drive(1'b0, 1'b0, 4'h0, 4'h1);
        tick("dp_release");
        tick("dp_held");
        check("dp_held_yv", 32'(bus.yv), 32'd0);
        check("dp_held_y", 32'(bus.y), 32'd1);

        // Single requester pulse of 3 cycles.
        cnt = 0;
        drive(1'b1, 1'b0, 4'h5, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick("single_on");
            cnt += int'(bus.gnt_a);
        end
        drive(1'b0, 1'b0, 4'h5, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick("single_off");
            cnt += int'(bus.gnt_a);
        end
        check("single_gnt_a_cycles", 32'(cnt), 32'd3);

        // Sustained contention from idle with B granted last.
        drive(1'b0, 1'b1, 4'h0, 4'h0);
        tick("cont_prep_b");
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        tick("cont_prep_idle");
        cnt = 0;
        drive(1'b1, 1'b1, 4'h9, 4'h6);
        for (int i = 0; i < 12; i++) begin
            tick("contention");
            cnt += int'(bus.gnt_a);
        end
        check("cont_gnt_a_cycles", 32'(cnt), TimeoutEn ? 32'd8 : 32'd12);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        tick("cont_drain0");
        tick("cont_drain1");

        // A alone for 10 cycles is never cut off.
        cnt = 0;
        drive(1'b1, 1'b0, 4'h7, 4'h0);
        for (int i = 0; i < 10; i++) begin
            tick("alone");
            cnt += int'(bus.gnt_a);
        end
        check("alone_gnt_a_cycles", 32'(cnt), 32'd10);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        tick("alone_drain");

        // Random traffic with sticky requests and occasional resets.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
            drive(ra, rb, W'($urandom), W'($urandom));
            if ($urandom_range(99) == 0) async_reset("rand_reset");
            tick("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
